// File: rtl/test_end_monitor.sv
// End-of-test monitor: watches tohost writes after a post-reset holdoff and
// reports pass, fail (with exit code) or timeout, plus cycle/non-exit counters.
module test_end_monitor #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 64,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic              core_clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic              tohost_valid,
    input  logic [DATA_W-1:0] tohost_data,
    output logic              tohost_ready,
    output logic              success,
    output logic              failure,
    output logic              timeout,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [15:0]       nonexit_count
);

    typedef enum logic [1:0] {StHold, StRun, StPass, StFail} state_e;

    localparam logic [7:0]       HoldLimit = 8'(HOLDOFF);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e              state_q, state_d;
    logic [7:0]          hold_cnt_q, hold_cnt_d;
    logic                ready_q, ready_d;
    logic                success_q, success_d;
    logic                failure_q, failure_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-2:0]   fail_code_q, fail_code_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [15:0]         nonexit_q, nonexit_d;

    logic                xfer;
    logic                exit_flag;
    logic [DATA_W-2:0]   exit_code;
    logic                timeout_hit;

    // ready_q is only ever high in RUN, so a transfer implies RUN
    assign xfer        = tohost_valid & ready_q;
    assign exit_flag   = tohost_data[0];
    assign exit_code   = tohost_data[DATA_W-1:1];
    assign timeout_hit = (max_cycles != '0) && (cycle_q >= max_cycles);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        success_d   = success_q;
        failure_d   = failure_q;
        timeout_d   = timeout_q;
        fail_code_d = fail_code_q;
        nonexit_d   = nonexit_q;
        cycle_d     = cycle_q;

        unique case (state_q)
            StHold: begin
                if (hold_cnt_q == HoldLimit) begin
                    state_d = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StRun: begin
                if (xfer && !exit_flag && (nonexit_q != 16'hFFFF)) begin
                    nonexit_d = nonexit_q + 16'd1;
                end
                // An exit word wins over a timeout seen in the same cycle
                if (xfer && exit_flag) begin
                    if (exit_code == '0) begin
                        state_d   = StPass;
                        success_d = 1'b1;
                    end else begin
                        state_d     = StFail;
                        failure_d   = 1'b1;
                        fail_code_d = exit_code;
                    end
                end else if (timeout_hit) begin
                    state_d     = StFail;
                    failure_d   = 1'b1;
                    timeout_d   = 1'b1;
                    fail_code_d = '0;
                end
            end
            default: ;
        endcase

        // Count freezes on the cycle that ends the test
        if (((state_d == StHold) || (state_d == StRun)) && (cycle_q != '1)) begin
            cycle_d = cycle_q + CntOne;
        end

        ready_d = (state_d == StRun);
    end

    always_ff @(posedge core_clock) begin
        if (!reset) begin
            state_q     <= StHold;
            hold_cnt_q  <= '0;
            ready_q     <= 1'b0;
            success_q   <= 1'b0;
            failure_q   <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            cycle_q     <= '0;
            nonexit_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            ready_q     <= ready_d;
            success_q   <= success_d;
            failure_q   <= failure_d;
            timeout_q   <= timeout_d;
            fail_code_q <= fail_code_d;
            cycle_q     <= cycle_d;
            nonexit_q   <= nonexit_d;
        end
    end

    assign tohost_ready  = ready_q;
    assign success       = success_q;
    assign failure       = failure_q;
    assign timeout       = timeout_q;
    assign fail_code     = fail_code_q;
    assign cycle_count   = cycle_q;
    assign nonexit_count = nonexit_q;

endmodule

// File: tb/tb_test_end_monitor.sv
// Scoreboard bench for test_end_monitor: stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_test_end_monitor;

    logic        core_clock;
    logic        reset;
    logic [63:0] max_cycles;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        tohost_ready;
    logic        success;
    logic        failure;
    logic        timeout;
    logic [30:0] fail_code;
    logic [63:0] cycle_count;
    logic [15:0] nonexit_count;

    test_end_monitor #(
        .DATA_W (32),
        .CNT_W  (64),
        .HOLDOFF(16)
    ) dut (
        .core_clock   (core_clock),
        .reset        (reset),
        .max_cycles   (max_cycles),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .tohost_ready (tohost_ready),
        .success      (success),
        .failure      (failure),
        .timeout      (timeout),
        .fail_code    (fail_code),
        .cycle_count  (cycle_count),
        .nonexit_count(nonexit_count)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic        rdy;
        logic        suc;
        logic        fl;
        logic        to;
        logic [30:0] code;
        logic [63:0] cnt;
        logic [15:0] nx;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        core_clock = 1'b0;
        forever #5 core_clock = ~core_clock;
    end

    always @(posedge core_clock) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come up
    initial begin
        exp_t e;
        forever begin
            @(negedge core_clock);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (tohost_ready !== e.rdy || success !== e.suc || failure !== e.fl ||
                             timeout !== e.to || fail_code !== e.code ||
                             cycle_count !== e.cnt || nonexit_count !== e.nx) begin
                    errors++;
                    $display("FAIL %s: got rdy=%b suc=%b fail=%b to=%b code=%h cnt=%0d nx=%h ; want rdy=%b suc=%b fail=%b to=%b code=%h cnt=%0d nx=%h",
                             e.name, tohost_ready, success, failure, timeout, fail_code,
                             cycle_count, nonexit_count, e.rdy, e.suc, e.fl, e.to, e.code,
                             e.cnt, e.nx);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Drive inputs, then advance one clock edge
    task automatic step(input logic rst, input logic vld, input logic [31:0] data,
                        input logic [63:0] maxc);
        reset        = rst;
        tohost_valid = vld;
        tohost_data  = data;
        max_cycles   = maxc;
        @(posedge core_clock);
        #2;
    endtask

    task automatic expect_out(input string name, input logic rdy, input logic suc,
                              input logic fl, input logic to, input logic [30:0] code,
                              input logic [63:0] cnt, input logic [15:0] nx);
        exp_t e;
        e.name = name; e.cyc = cyc; e.rdy = rdy; e.suc = suc; e.fl = fl; e.to = to;
        e.code = code; e.cnt = cnt; e.nx = nx;
        exp_q.push_back(e);
    endtask

    // Reset for one edge, then release and run k edges idle
    task automatic reset_and_run(input int k, input logic [63:0] maxc);
        step(1'b0, 1'b1, 32'h1, maxc);
        expect_out("reset_clears", 0, 0, 0, 0, '0, '0, '0);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, 32'h0, maxc);
    endtask

    initial begin
        reset = 1'b0; tohost_valid = 1'b1; tohost_data = 32'h2; max_cycles = '0;
        #2;
        // Power-on reset with valid already asserted
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h2, 64'd0);
        expect_out("por_state", 0, 0, 0, 0, '0, '0, '0);

        // Holdoff: ready must not rise until edge 17, no early transfer
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, 1'b1, 32'h2, 64'd0);
            expect_out($sformatf("holdoff_k%0d", k), (k >= 17), 0, 0, 0, '0, 64'(k), '0);
        end
        step(1'b1, 1'b1, 32'h2, 64'd0);
        expect_out("first_nonexit", 1, 0, 0, 0, '0, 64'd18, 16'd1);

        // Pass: count frozen at 18
        step(1'b1, 1'b1, 32'h1, 64'd0);
        expect_out("pass_entry", 0, 1, 0, 0, '0, 64'd18, 16'd1);
        step(1'b1, 1'b1, 32'h1, 64'd0);
        step(1'b1, 1'b0, 32'h0, 64'd0);
        expect_out("pass_sticky", 0, 1, 0, 0, '0, 64'd18, 16'd1);

        // Fail with exit code 0x15 (reset out of PASS first)
        reset_and_run(17, 64'd0);
        expect_out("run_again", 1, 0, 0, 0, '0, 64'd17, '0);
        step(1'b1, 1'b1, 32'h2B, 64'd0);
        expect_out("fail_entry", 0, 0, 1, 0, 31'h15, 64'd17, '0);
        step(1'b1, 1'b1, 32'h1, 64'd0);
        step(1'b1, 1'b0, 32'h0, 64'd0);
        expect_out("fail_sticky", 0, 0, 1, 0, 31'h15, 64'd17, '0);

        // Timeout at 100; small max_cycles during HOLD must be ignored
        reset_and_run(10, 64'd3);
        expect_out("hold_ignores_max", 0, 0, 0, 0, '0, 64'd10, '0);
        for (int i = 0; i < 90; i++) step(1'b1, 1'b0, 32'h0, 64'd100);
        expect_out("pre_timeout", 1, 0, 0, 0, '0, 64'd100, '0);
        step(1'b1, 1'b0, 32'h0, 64'd100);
        expect_out("timeout_entry", 0, 0, 1, 1, '0, 64'd100, '0);
        step(1'b1, 1'b1, 32'h1, 64'd100);
        step(1'b1, 1'b0, 32'h0, 64'd100);
        expect_out("timeout_frozen", 0, 0, 1, 1, '0, 64'd100, '0);

        // Exit write on the exact timeout cycle wins
        reset_and_run(100, 64'd100);
        expect_out("race_setup", 1, 0, 0, 0, '0, 64'd100, '0);
        step(1'b1, 1'b1, 32'h1, 64'd100);
        expect_out("exit_beats_timeout", 0, 1, 0, 0, '0, 64'd100, '0);

        // Non-exit saturation over 70000 writes
        reset_and_run(17, 64'd0);
        for (int n = 1; n <= 70000; n++) begin
            step(1'b1, 1'b1, 32'h2, 64'd0);
            if (n == 65534) expect_out("nx_fffe", 1, 0, 0, 0, '0, 64'(17 + n), 16'hFFFE);
            if (n == 65535) expect_out("nx_ffff", 1, 0, 0, 0, '0, 64'(17 + n), 16'hFFFF);
        end
        expect_out("nx_saturated", 1, 0, 0, 0, '0, 64'd70017, 16'hFFFF);
        step(1'b0, 1'b1, 32'h2, 64'd0);
        expect_out("midrun_reset", 0, 0, 0, 0, '0, '0, '0);
        step(1'b1, 1'b1, 32'h2, 64'd0);
        expect_out("hold_restart", 0, 0, 0, 0, '0, 64'd1, '0);

        step(1'b1, 1'b0, 32'h0, 64'd0);
        @(negedge core_clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test_end_monitor.md
TEST_END_MONITOR -- requirements
Module: test_end_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the tohost word.
REQ-002 SHALL have parameter CNT_W, default 64, width of the cycle counter and max_cycles.
REQ-003 SHALL have parameter HOLDOFF, default 16, number of post-reset cycles before tohost writes are accepted; legal range 1..255.
REQ-004 SHALL have port core_clock, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-low; the clock is core_clock.
REQ-006 SHALL have port max_cycles, input, CNT_W, timeout limit; 0 disables the timeout; sampled every cycle.
REQ-007 SHALL have port tohost_valid, input, 1, the harness presents a tohost word.
REQ-008 SHALL have port tohost_data, input, DATA_W, tohost word; bit0 is the exit flag and bits[DATA_W-1:1] are the exit code.
REQ-009 SHALL have port tohost_ready, output, 1, the monitor accepts a word this cycle.
REQ-010 SHALL have port success, output, 1, test passed (sticky).
REQ-011 SHALL have port failure, output, 1, test failed (sticky).
REQ-012 SHALL have port timeout, output, 1, the failure was caused by timeout.
REQ-013 SHALL have port fail_code, output, DATA_W-1, latched nonzero exit code.
REQ-014 SHALL have port cycle_count, output, CNT_W, cycles elapsed since reset release.
REQ-015 SHALL have port nonexit_count, output, 16, count of accepted words with bit0=0, saturating.

Function
REQ-016 SHALL implement four states: HOLD, RUN, PASS and FAIL; PASS and FAIL are terminal until reset.
REQ-017 SHALL stay in HOLD for exactly HOLDOFF cycles after reset release, counted by an 8-bit counter, and then enter RUN.
REQ-018 SHALL drive tohost_ready from a register, high only while the state is RUN.
REQ-019 SHALL complete a transfer on any cycle where tohost_valid and tohost_ready are both high; valid without ready has no effect.
REQ-020 SHALL, on a transfer with bit0=1 and code 0, enter PASS and assert success on the next cycle.
REQ-021 SHALL, on a transfer with bit0=1 and a nonzero code, enter FAIL, assert failure and latch fail_code on the next cycle.
REQ-022 SHALL, on a transfer with bit0=0, stay in RUN and increment nonexit_count, saturating at 0xFFFF.
REQ-023 SHALL increment cycle_count by 1 every cycle in HOLD and RUN, saturate it at all-ones, and freeze it in PASS and FAIL.
REQ-024 SHALL, while in RUN with max_cycles != 0 and registered cycle_count >= max_cycles, enter FAIL with timeout=1 and fail_code=0.
REQ-025 SHALL give an exit transfer priority over a timeout detected in the same cycle; the timeout flag stays 0.
REQ-026 SHALL never assert success and failure together; both are sticky once set.
REQ-027 SHALL set tohost_ready=0 on the cycle it enters PASS or FAIL, so no further word is accepted.
REQ-028 SHALL ignore max_cycles changes during HOLD; the timeout is evaluated only in RUN.

Reset
REQ-029 SHALL, when reset is low at a rising edge, force the state to HOLD and clear the holdoff counter.
REQ-030 SHALL hold every output at 0 during reset and on the first cycle after release: tohost_ready, success, failure, timeout, fail_code, cycle_count and nonexit_count.
REQ-031 SHALL abort any operation on a mid-run reset, including one in PASS or FAIL, with no transfer completing on the reset cycle.

Verification
REQ-032 SHALL pass this scenario: release reset with valid held high -> ready rises on cycle HOLDOFF+1 (17) after release and no transfer occurs earlier.
REQ-033 SHALL pass this scenario: write 0x00000001 -> success=1 on the next cycle, ready=0, cycle_count frozen, failure=0.
REQ-034 SHALL pass this scenario: write 0x0000002B -> failure=1, fail_code=0x15, timeout=0, success never set.
REQ-035 SHALL pass this scenario: max_cycles=100 with no write -> failure=1 and timeout=1 when cycle_count reaches 100, after which the count freezes.
REQ-036 SHALL pass this scenario: max_cycles=100 and write 0x1 on the exact timeout cycle -> success=1 and timeout=0.
REQ-037 SHALL pass this scenario: 70000 writes of 0x2 -> nonexit_count=0xFFFF and the state remains RUN; then pull reset low for 1 cycle -> all outputs 0 and HOLD restarts.
